// File: rtl/mux_channel_scanner.sv
// rtl/mux_channel_scanner.sv - N-channel direct/round-robin selector with optional invert and valid/ready output register.
// Define MUX_CHANNEL_SCANNER_SKIP_EN to make the scan jump straight to the next valid channel.
module mux_channel_scanner #(
    parameter int WIDTH = 8,
    parameter int N_CH  = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  invert,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] cand;
    logic [WIDTH-1:0] cand_data;
    logic             cand_valid;
    logic             load_en;
    logic             capture;

`ifdef MUX_CHANNEL_SCANNER_SKIP_EN
    logic             found_hi;
    logic             found_lo;
    logic [SEL_W-1:0] hi_ch;
    logic [SEL_W-1:0] lo_ch;

    // Cyclic search from ptr: lowest valid channel at or above ptr, else lowest below it.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        hi_ch    = '0;
        lo_ch    = '0;
        for (int c = N_CH - 1; c >= 0; c--) begin
            if (in_valid[c]) begin
                if (SEL_W'(c) >= ptr) begin
                    found_hi = 1'b1;
                    hi_ch    = SEL_W'(c);
                end else begin
                    found_lo = 1'b1;
                    lo_ch    = SEL_W'(c);
                end
            end
        end
    end
`endif

    always_comb begin
        load_en = !out_valid || out_ready;
        cand    = mode ? ptr : sel;
`ifdef MUX_CHANNEL_SCANNER_SKIP_EN
        if (mode) begin
            cand = found_hi ? hi_ch : (found_lo ? lo_ch : ptr);
        end
`endif
        // Codes at or above N_CH match no channel, so they never capture.
        cand_valid = 1'b0;
        cand_data  = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (cand == SEL_W'(c)) begin
                cand_valid = in_valid[c];
                cand_data  = in_data[c*WIDTH +: WIDTH];
            end
        end
        capture = !rst && load_en && cand_valid;
        for (int c = 0; c < N_CH; c++) begin
            in_ready[c] = capture && (cand == SEL_W'(c));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else begin
            if (capture) begin
                out_data  <= invert ? ~cand_data : cand_data;
                out_ch    <= cand;
                out_valid <= 1'b1;
            end else if (load_en) begin
                out_valid <= 1'b0;
            end
`ifdef MUX_CHANNEL_SCANNER_SKIP_EN
            if (mode && capture) begin
                ptr <= (cand == SEL_W'(N_CH - 1)) ? '0 : cand + SEL_W'(1);
            end
`else
            if (mode && load_en) begin
                ptr <= (ptr == SEL_W'(N_CH - 1)) ? '0 : ptr + SEL_W'(1);
            end
`endif
        end
    end

endmodule

// File: tb/tb_mux_channel_scanner.sv
// tb/tb_mux_channel_scanner.sv - self-checking bench for mux_channel_scanner (N_CH=4 and N_CH=3 instances).
module tb_mux_channel_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] din;
    logic [3:0]  vin;
    logic        mode, inv, ordy;
    logic [1:0]  sel;
    logic [3:0]  rdy4;
    logic [2:0]  rdy3;
    logic [7:0]  od4, od3;
    logic [1:0]  och4, och3;
    logic        ov4, ov3;

    int checks = 0;
    int errors = 0;

    int m_ov[2], m_od[2], m_och[2], m_ptr[2];
    int n_ov[2], n_od[2], n_och[2], n_ptr[2];
    int r_exp[2];

    always #5 clk = ~clk;

    mux_channel_scanner #(.WIDTH(8), .N_CH(4)) u4 (
        .clk(clk), .rst(rst), .in_data(din), .in_valid(vin), .in_ready(rdy4),
        .mode(mode), .sel(sel), .invert(inv), .out_data(od4), .out_ch(och4),
        .out_valid(ov4), .out_ready(ordy)
    );

    mux_channel_scanner #(.WIDTH(8), .N_CH(3)) u3 (
        .clk(clk), .rst(rst), .in_data(din[23:0]), .in_valid(vin[2:0]), .in_ready(rdy3),
        .mode(mode), .sel(sel), .invert(inv), .out_data(od3), .out_ch(och3),
        .out_valid(ov3), .out_ready(ordy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour for instance i with n channels, from the current tb inputs.
    task automatic model_eval(input int i);
        int  n, c, j;
        bit  take, cap;
        n = (i == 0) ? 4 : 3;
        n_ov[i] = m_ov[i]; n_od[i] = m_od[i]; n_och[i] = m_och[i]; n_ptr[i] = m_ptr[i];
        r_exp[i] = 0;
        if (rst) begin
            n_ov[i] = 0; n_od[i] = 0; n_och[i] = 0; n_ptr[i] = 0;
            return;
        end
        take = (m_ov[i] == 0) || ordy;
        c = -1;
        if (!mode) begin
            c = int'(sel);
        end else begin
`ifdef MUX_CHANNEL_SCANNER_SKIP_EN
            for (int k = 0; k < n; k++) begin
                j = (m_ptr[i] + k) % n;
                if (c < 0 && vin[j]) c = j;
            end
`else
            c = m_ptr[i];
`endif
        end
        cap = take && c >= 0 && c < n && vin[c];
        if (cap) begin
            r_exp[i] = 1 << c;
            n_od[i]  = inv ? (~din[8*c +: 8]) & 8'hFF : din[8*c +: 8];
            n_och[i] = c;
            n_ov[i]  = 1;
        end else if (take) begin
            n_ov[i] = 0;
        end
`ifdef MUX_CHANNEL_SCANNER_SKIP_EN
        if (mode && cap) n_ptr[i] = (c + 1) % n;
`else
        if (mode && take) n_ptr[i] = (m_ptr[i] + 1) % n;
`endif
    endtask

    // One clock: check in_ready before the edge, outputs one tick after it.
    task automatic step();
        #1;
        model_eval(0);
        model_eval(1);
        chk("in_ready4", rdy4, r_exp[0]);
        chk("in_ready3", rdy3, r_exp[1]);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            m_ov[i] = n_ov[i]; m_od[i] = n_od[i]; m_och[i] = n_och[i]; m_ptr[i] = n_ptr[i];
        end
        chk("out_valid4", ov4, m_ov[0]);
        chk("out_valid3", ov3, m_ov[1]);
        if (m_ov[0] != 0) begin
            chk("out_data4", od4, m_od[0]);
            chk("out_ch4", och4, m_och[0]);
        end
        if (m_ov[1] != 0) begin
            chk("out_data3", od3, m_od[1]);
            chk("out_ch3", och3, m_och[1]);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1; vin = 4'hF; ordy = 1'b1;
        for (int k = 0; k < cycles; k++) begin
            step();
            chk("rst_out_data4", od4, 0);
            chk("rst_out_ch4", och4, 0);
            chk("rst_out_data3", od3, 0);
            chk("rst_out_ch3", och3, 0);
        end
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] scan_ch[5];
        logic [7:0] scan_dat[5];
        scan_ch  = '{8'd0, 8'd1, 8'd2, 8'd0, 8'd1};
        scan_dat = '{8'h10, 8'h11, 8'h12, 8'h10, 8'h11};
        rst = 1'b1; din = '0; vin = '0; mode = 1'b0; inv = 1'b0; ordy = 1'b1; sel = '0;
        for (int i = 0; i < 2; i++) begin
            m_ov[i] = 0; m_od[i] = 0; m_och[i] = 0; m_ptr[i] = 0;
        end
        @(posedge clk);
        #1;

        do_reset(2);

        // Direct select with invert
        mode = 1'b0; sel = 2'd2; din = 32'h11A52233; vin = 4'b0100; inv = 1'b1; ordy = 1'b1;
        step();
        chk("direct_out_data", od4, 8'h5A);
        chk("direct_out_ch", och4, 2);
        chk("direct_out_valid", ov4, 1);

        // Backpressure: capture ch1, then stall three cycles in scan mode
        sel = 2'd1; din = 32'h00003C00; vin = 4'b0010; inv = 1'b0;
        step();
        ordy = 1'b0; mode = 1'b1; vin = 4'hF; inv = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_hold_data", od4, 8'h3C);
            chk("bp_hold_ready", rdy4, 0);
        end
        ordy = 1'b1;
        for (int k = 0; k < 4; k++) step();

        // Scan wrap on the 3-channel instance from ptr=0
        do_reset(1);
        mode = 1'b1; vin = 4'hF; inv = 1'b0; ordy = 1'b1; din = 32'h13121110;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("scan3_ch", och3, scan_ch[k]);
            chk("scan3_data", od3, scan_dat[k]);
        end

        // Out-of-range select on the 3-channel instance
        mode = 1'b0; sel = 2'd3;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("oor_valid3", ov3, 0);
            chk("oor_ready3", rdy3, 0);
        end

        // Sparse valid pattern in scan mode (exercises idle steps or skipping)
        do_reset(1);
        mode = 1'b1; vin = 4'b0010; din = 32'hD3C2B1A0;
        step();
        vin = 4'b1001;
        for (int k = 0; k < 6; k++) step();

        // Randomized traffic with occasional mid-transfer reset
        for (int k = 0; k < 400; k++) begin
            din  = $urandom;
            vin  = 4'($urandom);
            mode = 1'($urandom);
            sel  = 2'($urandom);
            inv  = 1'($urandom);
            ordy = ($urandom_range(0, 3) != 0);
            rst  = ($urandom_range(0, 49) == 0);
            step();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
